// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the processor memory-request front end.
package proc_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 512;

    localparam int unsigned CH_IFILL  = 0;
    localparam int unsigned CH_DFILL  = 1;
    localparam int unsigned CH_DEVICT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_e;

    // Number of byte-offset bits inside one line
    function automatic int unsigned line_off_w(input int unsigned line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: fixed-priority (lowest index) or round-robin grant with
// a pointer that advances past the winner whenever a grant is taken.
module rr_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic                      gnt_en_i,
    output logic [NUM_CH-1:0]         gnt_oh_c,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx_c
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] scan_idx;
    logic             found;

    // Scan order starts at the pointer in round-robin mode, at 0 otherwise
    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 0) begin
                scan_idx = IDX_W'(k);
            end else begin
                scan_idx = IDX_W'((32'(ptr_q) + k) % NUM_CH);
            end
            if (!found && req_i[scan_idx]) begin
                found              = 1'b1;
                gnt_oh_c[scan_idx] = 1'b1;
                gnt_idx_c          = scan_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((ARB_MODE != 0) && gnt_en_i && (|req_i)) begin
            ptr_d = (32'(gnt_idx_c) == NUM_CH - 1) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Memory-controller front end: arbitrates NUM_CH line requesters onto one
// host DMA port with a single outstanding transaction and a WAIT timeout.
module mem_req_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned LINE_W      = LINE_W_DEF,
    parameter int unsigned ARB_MODE    = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        reqValid,
    input  logic [NUM_CH-1:0]        reqWrite,
    input  logic [NUM_CH*ADDR_W-1:0] reqAddr,
    input  logic [NUM_CH*LINE_W-1:0] reqWData,
    output logic [NUM_CH-1:0]        rspValid,
    output logic                     rspErr,
    output logic [LINE_W-1:0]        rspData,
    output logic                     busy,
    output logic                     memReq,
    output logic                     memWrite,
    output logic [ADDR_W-1:0]        memAddr,
    output logic [LINE_W-1:0]        memWData,
    input  logic                     memAck,
    input  logic                     memDone,
    input  logic [LINE_W-1:0]        memRData
);

    localparam int unsigned OFF_W = line_off_w(LINE_W);
    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    mem_state_e        state_q, state_d;
    logic [NUM_CH-1:0] sel_q, sel_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;

    logic              gnt_en;
    logic              timeout_hit;
    logic              timeout_err;
    logic [NUM_CH-1:0] gnt_oh_c;
    logic [IDX_W-1:0]  gnt_idx_c;
    logic [ADDR_W-1:0] addr_sel;
    logic [LINE_W-1:0] wdata_sel;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .req_i     (reqValid),
        .gnt_en_i  (gnt_en),
        .gnt_oh_c  (gnt_oh_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Payload mux for the winning channel
    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx_c == IDX_W'(i)) begin
                addr_sel  = reqAddr[i*ADDR_W +: ADDR_W];
                wdata_sel = reqWData[i*LINE_W +: LINE_W];
            end
        end
    end

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        gnt_en      = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|reqValid) begin
                    gnt_en             = 1'b1;
                    sel_d              = gnt_oh_c;
                    wr_d               = |(reqWrite & gnt_oh_c);
                    addr_d             = addr_sel;
                    addr_d[OFF_W-1:0]  = '0;
                    wdata_d            = wdata_sel;
                    cnt_d              = '0;
                    state_d            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (memAck) begin
                    if (memDone) begin
                        state_d = ST_RESP;
                        if (!wr_q) rsp_data_d = memRData;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (memDone) begin
                    state_d = ST_RESP;
                    if (!wr_q) rsp_data_d = memRData;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d     = ST_RESP;
                        timeout_err = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it
        mem_req_d   = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP) ? sel_d : '0;
        rsp_err_d   = (state_d == ST_RESP) && timeout_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign rspValid = rsp_valid_q;
    assign rspErr   = rsp_err_q;
    assign rspData  = rsp_data_q;
    assign busy     = busy_q;
    assign memReq   = mem_req_q;
    assign memWrite = wr_q;
    assign memAddr  = addr_q;
    assign memWData = wdata_q;

endmodule
